twowire_onehot_rx: RTL and testbench
====================================

// Module: twowire_onehot_rx
// PURPOSE
//  Parametrised two-wire (scl/sda) frame receiver and one-hot decoder, fully synchronous to clk.
//  Samples scl_i/sda_i asynchronously and detects START (sda fall while scl high) and STOP (sda rise while scl high).
//  Shifts in an optional address field and a DATA_W-bit data word, MSB first, one bit per scl rise.
//  On a valid STOP, latches the word and drives a 2**DATA_W one-hot output for the output/driver stage.
// PARAMETERS
//  DATA_W   4  data bits per frame (1..8); outhigh width = 2**DATA_W
//  ADDR_W   0  address bits sent before data (0 = no address field; frames always accepted)
//  ADDR     0  ADDR_W-bit address this instance accepts
//  FILT_LEN 3  consecutive identical synced samples before a filtered line changes (>=1)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            synchronous, active-high reset
//  scl_i      in   1            serial clock, asynchronous to clk
//  sda_i      in   1            serial data, asynchronous to clk
//  outhigh    out  2**DATA_W    registered one-hot decode of last accepted word
//  data_o     out  DATA_W       registered raw value of last accepted word
//  data_valid out  1            1-cycle pulse: outhigh/data_o updated this cycle
//  frame_err  out  1            1-cycle pulse: malformed frame discarded
//  busy       out  1            high in SHIFT or WAIT_STOP
// BEHAVIOUR
//  Reset: clk and rst only; reset is synchronous and active-high.
//   On rst: all outputs 0, state IDLE, bit counter 0, filters load 1 (idle bus).
//   rst mid-frame discards the partial frame; no pulses are issued.
//  Input path: 2-FF synchroniser per line, then a filter.
//   A filtered line changes only after FILT_LEN equal consecutive synced samples.
//   Edge strobes (scl_rise, sda_fall, sda_rise) are single-cycle and derived from the filtered lines.
//   START = sda_fall & scl_f. STOP = sda_rise & scl_f.
//  Frame: FRAME_W = ADDR_W+DATA_W bits, MSB first. Each scl_rise shifts sda_f into the shift register.
//  FSM:
//   IDLE: START -> SHIFT (cnt=0). scl_rise is ignored.
//   SHIFT: scl_rise shifts the bit and increments cnt. When cnt reaches FRAME_W -> WAIT_STOP.
//    STOP with cnt<FRAME_W -> frame_err, then IDLE.
//    START with cnt>0 -> frame_err, restart SHIFT (cnt=0). START with cnt==0 restarts silently.
//   WAIT_STOP: STOP -> accept check, then IDLE. START -> frame_err, then SHIFT (cnt=0).
//    scl_rise -> frame_err (overlength frame), then IDLE.
//  Accept check on STOP in WAIT_STOP:
//   If ADDR_W==0 or addr field==ADDR: on the next clk, data_o<=word, outhigh<=onehot(word), data_valid=1.
//   Address mismatch: silently ignored (no pulse, outputs hold).
//  One-hot map: word k (k!=0) -> outhigh[k-1]; word 0 -> outhigh[2**DATA_W-1]. Exactly one bit set after the first accept.
//  Latency: STOP strobe at cycle S -> outputs and data_valid at S+1.
//   End to end, add 2 sync cycles + FILT_LEN cycles from the sda_i edge.
//  Outputs hold between accepts. data_valid and frame_err are never high together. busy = (state!=IDLE).
//  If scl and sda edges settle in the same cycle, the scl_rise is processed before the START/STOP check.
// TESTING
//  (defaults) START, bits 0,0,1,1, STOP -> data_o=3, outhigh=16'h0004, one data_valid pulse.
//  Frame 0000 -> outhigh=16'h8000; frame 1111 -> outhigh=16'h4000; outputs hold after each pulse.
//  START, 2 bits, STOP -> frame_err pulse, outhigh unchanged, busy back to 0.
//  START, 5 scl pulses -> frame_err on the 5th scl_rise; a later STOP is ignored.
//  ADDR_W=3, ADDR=5: addr 101 data 0010 -> outhigh bit1 set; addr 100 -> no pulse.
//  1-cycle sda glitch while scl high (FILT_LEN=3) -> no START. rst mid-frame -> all outputs 0.

Source files
------------

// File: rtl/twowire_onehot_rx.sv
// Two-wire (scl/sda) frame receiver: synchronise, filter, shift MSB first, and latch
// the data word plus its one-hot decode on a valid STOP.
module twowire_onehot_rx #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 0,
  parameter int ADDR     = 0,
  parameter int FILT_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic [2**DATA_W-1:0]   outhigh,
  output logic [DATA_W-1:0]      data_o,
  output logic                   data_valid,
  output logic                   frame_err,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int FW  = ADDR_W + DATA_W;
  localparam int OW  = 2**DATA_W;
  localparam int CW  = $clog2(FW + 1);
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT     = 2'd1;
  localparam logic [1:0] WAIT_STOP = 2'd2;

  // Line vectors: bit 0 is scl, bit 1 is sda.
  logic [1:0]     sync1, sync2, filt, filt_q;
  logic [FCW-1:0] fcnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_q <= filt;
      // fcnt counts consecutive synced samples that disagree with the filtered line.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, sda_fall, sda_rise, start, stop;

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign sda_fall = ~filt[1] & filt_q[1];
  assign sda_rise = filt[1] & ~filt_q[1];
  assign start    = sda_fall & scl_f;
  assign stop     = sda_rise & scl_f;

  logic [1:0]        state, st_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FW-1:0]     sh, sh_n;
  logic              do_shift, err_n, acc_n, addr_ok;
  logic [DATA_W-1:0] word;
  logic [OW-1:0]     oh;

  // The shift happens first so a STOP settling in the same cycle sees the full frame.
  assign do_shift = (state == SHIFT) && scl_rise;

  always_comb begin
    sh_n = sh;
    if (do_shift) sh_n = (sh << 1) | FW'(sda_f);
  end

  assign word = sh_n[DATA_W-1:0];

  generate
    if (ADDR_W > 0) begin : g_addr
      assign addr_ok = (sh_n[FW-1:DATA_W] == ADDR_W'(ADDR));
    end else begin : g_noaddr
      assign addr_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    oh = '0;
    if (word == '0) oh[OW-1] = 1'b1;
    else            oh[word - 1'b1] = 1'b1;
  end

  always_comb begin
    st_n  = state;
    cnt_n = cnt;
    err_n = 1'b0;
    acc_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          st_n  = SHIFT;
          cnt_n = '0;
        end
      end
      SHIFT: begin
        if (do_shift) cnt_n = cnt + 1'b1;
        if (start) begin
          err_n = (cnt_n != '0);
          cnt_n = '0;
        end else if (stop) begin
          st_n = IDLE;
          if (cnt_n == CW'(FW)) acc_n = addr_ok;
          else                  err_n = 1'b1;
        end else if (cnt_n == CW'(FW)) begin
          st_n = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        if (scl_rise) begin
          err_n = 1'b1;
          st_n  = IDLE;
        end else if (start) begin
          err_n = 1'b1;
          st_n  = SHIFT;
          cnt_n = '0;
        end else if (stop) begin
          acc_n = addr_ok;
          st_n  = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      outhigh    <= '0;
      data_o     <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= st_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      data_valid <= acc_n;
      frame_err  <= err_n;
      if (acc_n) begin
        data_o  <= word;
        outhigh <= oh;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_twowire_onehot_rx.sv
// Bench for twowire_onehot_rx: default instance plus an addressed instance (ADDR_W=3, ADDR=5).
module tb_twowire_onehot_rx;

  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl0 = 1'b1, sda0 = 1'b1, scl1 = 1'b1, sda1 = 1'b1;
  logic [15:0] oh0, oh1;
  logic [3:0]  d0, d1;
  logic        dv0, fe0, busy0, dv1, fe1, busy1;
  logic [1:0]  st0, st1;

  twowire_onehot_rx dut0 (
    .clk(clk), .rst(rst), .scl_i(scl0), .sda_i(sda0), .outhigh(oh0), .data_o(d0),
    .data_valid(dv0), .frame_err(fe0), .busy(busy0), .state_dbg(st0)
  );

  twowire_onehot_rx #(.DATA_W(4), .ADDR_W(3), .ADDR(5), .FILT_LEN(3)) dut1 (
    .clk(clk), .rst(rst), .scl_i(scl1), .sda_i(sda1), .outhigh(oh1), .data_o(d1),
    .data_valid(dv1), .frame_err(fe1), .busy(busy1), .state_dbg(st1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int dv0_n = 0, fe0_n = 0, dv1_n = 0, fe1_n = 0, both_n = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  always @(negedge clk) begin
    if (dv0) begin
      dv0_n++;
      got_q.push_back(d0);
    end
    if (fe0) fe0_n++;
    if (dv1) dv1_n++;
    if (fe1) fe1_n++;
    if ((dv0 && fe0) || (dv1 && fe1)) both_n++;
  end

  function automatic logic [15:0] ref_oh(input logic [3:0] k);
    return (k == 4'd0) ? 16'h8000 : (16'h1 << (k - 1));
  endfunction

  task automatic hold();
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic c, input logic d);
    if (sel == 0) begin scl0 = c; sda0 = d; end
    else          begin scl1 = c; sda1 = d; end
    hold();
  endtask

  task automatic bus_start(input int sel);
    drive(sel, 1'b1, 1'b0);
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic bus_bit(input int sel, input logic b);
    drive(sel, 1'b0, b);
    drive(sel, 1'b1, b);
    drive(sel, 1'b0, b);
  endtask

  // Last bit merged with STOP: a 1 rises together with scl, a 0 is clocked then released.
  task automatic bus_end(input int sel, input logic b);
    drive(sel, 1'b0, 1'b0);
    if (b) drive(sel, 1'b1, 1'b1);
    else begin
      drive(sel, 1'b1, 1'b0);
      drive(sel, 1'b1, 1'b1);
    end
  endtask

  task automatic bus_stop(input int sel);
    drive(sel, 1'b0, 1'b0);
    drive(sel, 1'b1, 1'b0);
    drive(sel, 1'b1, 1'b1);
  endtask

  task automatic send_frame(input int sel, input logic [15:0] bits, input int n);
    bus_start(sel);
    for (int i = n - 1; i > 0; i--) bus_bit(sel, bits[i]);
    bus_end(sel, bits[0]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (oh0 !== 16'h0) begin bad++; $display("FAIL reset_oh0 got=%h exp=0", oh0); end
    total++; if (d0 !== 4'h0) begin bad++; $display("FAIL reset_d0 got=%h exp=0", d0); end
    total++; if ({dv0, fe0, busy0} !== 3'b000) begin bad++; $display("FAIL reset_flags0 got=%b exp=000", {dv0, fe0, busy0}); end
    total++; if ({oh1, dv1, fe1, busy1} !== 19'h0) begin bad++; $display("FAIL reset_dut1 got=%h exp=0", {oh1, dv1, fe1, busy1}); end
    rst = 1'b0;
    hold();
  endtask

  task automatic test_basic();
    int dv_s, fe_s;
    dv_s = dv0_n; fe_s = fe0_n;
    send_frame(0, 16'b0011, 4);
    total++; if (dv0_n - dv_s !== 1) begin bad++; $display("FAIL basic_dv_pulses got=%0d exp=1", dv0_n - dv_s); end
    total++; if (d0 !== 4'd3) begin bad++; $display("FAIL basic_data got=%h exp=3", d0); end
    total++; if (oh0 !== 16'h0004) begin bad++; $display("FAIL basic_oh got=%h exp=0004", oh0); end
    total++; if (fe0_n !== fe_s) begin bad++; $display("FAIL basic_fe got=%0d exp=%0d", fe0_n, fe_s); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy0); end
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (oh0 !== 16'h0004 || dv0_n - dv_s !== 1) begin bad++; $display("FAIL basic_hold oh=%h pulses=%0d exp oh=0004 pulses=1", oh0, dv0_n - dv_s); end
  endtask

  task automatic test_corners();
    logic [3:0] w;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 4'h0 : 4'hf;
      send_frame(0, {12'h0, w}, 4);
      total++; if (d0 !== w) begin bad++; $display("FAIL corner_data got=%h exp=%h", d0, w); end
      total++; if (oh0 !== ref_oh(w)) begin bad++; $display("FAIL corner_oh got=%h exp=%h", oh0, ref_oh(w)); end
    end
  endtask

  task automatic test_short();
    int dv_s, fe_s;
    logic [15:0] oh_s;
    dv_s = dv0_n; fe_s = fe0_n; oh_s = ref_oh(4'hf);
    bus_start(0);
    bus_bit(0, 1'b1);
    bus_bit(0, 1'b0);
    bus_stop(0);
    @(negedge clk);
    total++; if (fe0_n - fe_s !== 1) begin bad++; $display("FAIL short_fe got=%0d exp=1", fe0_n - fe_s); end
    total++; if (dv0_n !== dv_s) begin bad++; $display("FAIL short_dv got=%0d exp=%0d", dv0_n, dv_s); end
    total++; if (oh0 !== oh_s) begin bad++; $display("FAIL short_oh got=%h exp=%h", oh0, oh_s); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL short_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_overlength();
    int dv_s, fe_s;
    dv_s = dv0_n; fe_s = fe0_n;
    bus_start(0);
    for (int i = 0; i < 4; i++) bus_bit(0, 1'(i));
    @(negedge clk);
    total++; if (busy0 !== 1'b1 || fe0_n !== fe_s) begin bad++; $display("FAIL over_wait busy=%b fe=%0d exp busy=1 fe=0", busy0, fe0_n - fe_s); end
    bus_bit(0, 1'b1);
    @(negedge clk);
    total++; if (fe0_n - fe_s !== 1) begin bad++; $display("FAIL over_fe got=%0d exp=1", fe0_n - fe_s); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL over_busy got=%b exp=0", busy0); end
    bus_stop(0);
    @(negedge clk);
    total++; if (fe0_n - fe_s !== 1 || dv0_n !== dv_s) begin bad++; $display("FAIL over_stop fe=%0d dv=%0d exp fe=1 dv=0", fe0_n - fe_s, dv0_n - dv_s); end
    total++; if (oh0 !== ref_oh(4'hf)) begin bad++; $display("FAIL over_oh got=%h exp=%h", oh0, ref_oh(4'hf)); end
  endtask

  task automatic test_addr();
    int dv_s, fe_s;
    dv_s = dv1_n; fe_s = fe1_n;
    send_frame(1, {9'h0, 3'b101, 4'b0010}, 7);
    total++; if (dv1_n - dv_s !== 1) begin bad++; $display("FAIL addr_match_dv got=%0d exp=1", dv1_n - dv_s); end
    total++; if (oh1 !== 16'h0002 || d1 !== 4'd2) begin bad++; $display("FAIL addr_match_out oh=%h d=%h exp oh=0002 d=2", oh1, d1); end
    send_frame(1, {9'h0, 3'b100, 4'b0111}, 7);
    total++; if (dv1_n - dv_s !== 1 || fe1_n !== fe_s) begin bad++; $display("FAIL addr_miss_pulse dv=%0d fe=%0d exp dv=1 fe=0", dv1_n - dv_s, fe1_n - fe_s); end
    total++; if (oh1 !== 16'h0002 || d1 !== 4'd2) begin bad++; $display("FAIL addr_miss_out oh=%h d=%h exp oh=0002 d=2", oh1, d1); end
  endtask

  task automatic test_glitch();
    int fe_s;
    fe_s = fe0_n;
    @(posedge clk); #1 sda0 = 1'b0;
    @(posedge clk); #1 sda0 = 1'b1;
    hold();
    @(negedge clk);
    total++; if (busy0 !== 1'b0 || fe0_n !== fe_s) begin bad++; $display("FAIL glitch busy=%b fe=%0d exp busy=0 fe=0", busy0, fe0_n - fe_s); end
  endtask

  task automatic test_random();
    logic [3:0] w;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      w = 4'($urandom_range(0, 15));
      exp_q.push_back(w);
      send_frame(0, {12'h0, w}, 4);
      total++; if (oh0 !== ref_oh(w) || d0 !== w) begin bad++; $display("FAIL rand_out word=%h oh=%h d=%h exp oh=%h", w, oh0, d0, ref_oh(w)); end
    end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      total++; if (got_q[0] !== w) begin bad++; $display("FAIL rand_sb got=%h exp=%h", got_q[0], w); end
      void'(got_q.pop_front());
    end
  endtask

  task automatic test_rst_mid();
    int dv_s, fe_s;
    bus_start(0);
    bus_bit(0, 1'b1);
    bus_bit(0, 1'b0);
    @(negedge clk);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy0); end
    dv_s = dv0_n; fe_s = fe0_n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (oh0 !== 16'h0 || d0 !== 4'h0 || busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_out oh=%h d=%h busy=%b exp all 0", oh0, d0, busy0); end
    #1 rst = 1'b0;
    hold();
    drive(0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (dv0_n !== dv_s || fe0_n !== fe_s || busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_after dv=%0d fe=%0d busy=%b exp 0 0 0", dv0_n - dv_s, fe0_n - fe_s, busy0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_short();
    test_overlength();
    test_addr();
    test_glitch();
    test_random();
    test_rst_mid();
    total++; if (both_n !== 0) begin bad++; $display("FAIL dv_fe_overlap got=%0d exp=0", both_n); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
